// File: rtl/instr_mem_sync.sv
// instr_mem_sync: loadable instruction memory with zero-fill after reset and a 1-cycle registered fetch
module instr_mem_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter bit BYTE_ADDR = 1'b1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_en,
    input  logic [IDX_W-1:0]      ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  busy,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  addr_fault
);
    typedef enum logic {CLEAR, READY} state_e;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);
    state_e state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic valid_q, valid_d, fault_q, fault_d;
    logic [ADDR_WIDTH-1:0] idx;
    logic [IDX_W-1:0] ridx, waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic fault, ld_ok, we;

    assign idx = BYTE_ADDR ? fetch_addr >> 2 : fetch_addr;
    assign ridx = IDX_W'(idx);
    assign fault = (BYTE_ADDR && fetch_addr[1:0] != 2'b00) || 32'(idx) >= 32'(DEPTH);
    assign ld_ok = state_q == READY && ld_en && {1'b0, ld_addr} < DEPTH_W;
    // single write port shared by the zero-fill sweep and program loads
    assign we = !reset && (state_q == CLEAR || ld_ok);
    assign waddr = state_q == CLEAR ? clr_ptr_q : ld_addr;
    assign wdata = state_q == CLEAR ? '0 : ld_data;
    assign busy = state_q == CLEAR;
    assign ld_ready = state_q == READY;
    assign instr = instr_q;
    assign instr_valid = valid_q;
    assign addr_fault = fault_q;

    always_comb begin
        state_d = state_q;
        clr_ptr_d = clr_ptr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            state_d = clr_ptr_q == LAST ? READY : CLEAR;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!fetch_stall) begin
            valid_d = fetch_req;
            fault_d = fetch_req && fault;
            instr_d = !fetch_req ? instr_q : fault ? NOP_WORD : mem[ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_ptr_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_ptr_q <= clr_ptr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // read happens in the comb block, so a same-cycle write is seen only by later fetches
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed and random checks of instr_mem_sync against an array-based reference model
module tb_instr_mem_sync;
    localparam int DEPTH = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic reset, ld_en, fetch_req, fetch_stall;
    logic [5:0] ld_addr;
    logic [31:0] ld_data;
    logic [8:0] fetch_addr;
    logic ld_ready, busy, instr_valid, addr_fault;
    logic [31:0] instr;
    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];
    int clear_left = 0;
    logic [31:0] exp_instr = '0;
    logic exp_valid = 1'b0;
    logic exp_fault = 1'b0;

    always #5 clk = ~clk;

    instr_mem_sync #(
        .DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(9), .BYTE_ADDR(1'b1), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .busy(busy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic le, input logic [5:0] la,
                        input logic [31:0] ld, input logic fr, input logic [8:0] fa, input logic fs);
        int wi;
        @(negedge clk);
        reset = r; ld_en = le; ld_addr = la; ld_data = ld;
        fetch_req = fr; fetch_addr = fa; fetch_stall = fs;
        @(posedge clk);
        wi = int'(fa) / 4;
        if (r) begin
            clear_left = DEPTH;
            foreach (model_mem[i]) model_mem[i] = '0;
            exp_instr = '0; exp_valid = 1'b0; exp_fault = 1'b0;
        end else if (clear_left > 0) begin
            clear_left--;
            exp_valid = 1'b0; exp_fault = 1'b0;
        end else begin
            if (!fs) begin
                exp_valid = fr;
                exp_fault = fr && (fa % 4 != 0 || wi >= DEPTH);
                if (fr) exp_instr = exp_fault ? NOP : model_mem[wi];
            end
            if (le && int'(la) < DEPTH) model_mem[la] = ld;
        end
        #1;
        chk({tag, ".instr"}, instr, exp_instr);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(exp_valid));
        chk({tag, ".fault"}, 32'(addr_fault), 32'(exp_fault));
        chk({tag, ".busy"}, 32'(busy), 32'(clear_left > 0));
        chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(clear_left == 0));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 9'd0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [5:0] a, input logic [31:0] d);
        step(tag, 1'b0, 1'b1, a, d, 1'b0, 9'd0, 1'b0);
    endtask

    task automatic fetch(input string tag, input logic [8:0] a);
        step(tag, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, a, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        foreach (model_mem[i]) model_mem[i] = '0;
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
        // 1: zero-fill lasts DEPTH cycles, then a fetch reads zero
        step("rst", 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 9'd0, 1'b0);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 70; i++) begin
            step("clr", 1'b0, 1'b1, 6'd2, 32'hdead_beef, 1'b1, 9'h010, 1'b0);
            if (busy) busy_cnt++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd64);
        fetch("t1_fetch", 9'h010);
        chk("t1_instr", instr, 32'h0);
        // 2: loads then back-to-back fetches
        load("t2_ld0", 6'd0, 32'h2002_0005);
        load("t2_ld3", 6'd3, 32'h00e2_2025);
        fetch("t2_f0", 9'h000);
        chk("t2_instr0", instr, 32'h2002_0005);
        fetch("t2_f1", 9'h00c);
        chk("t2_instr1", instr, 32'h00e2_2025);
        // 3: misaligned and out-of-range fetches
        fetch("t3_mis", 9'h006);
        chk("t3_mis_fault", 32'(addr_fault), 32'd1);
        chk("t3_mis_instr", instr, NOP);
        fetch("t3_oor", 9'h100);
        chk("t3_oor_fault", 32'(addr_fault), 32'd1);
        chk("t3_oor_instr", instr, NOP);
        // 4: same-cycle load and fetch returns the old word
        step("t4_coll", 1'b0, 1'b1, 6'd5, 32'hAAAA_0000, 1'b1, 9'h014, 1'b0);
        chk("t4_old", instr, 32'h0);
        fetch("t4_refetch", 9'h014);
        chk("t4_new", instr, 32'hAAAA_0000);
        // 5: stall holds outputs and blocks new requests
        load("t5_ld", 6'd7, 32'h0064_2824);
        fetch("t5_f", 9'h01c);
        for (int i = 0; i < 3; i++) begin
            step("t5_stall", 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 9'h000, 1'b1);
            chk("t5_hold", instr, 32'h0064_2824);
        end
        idle("t5_idle");
        chk("t5_idle_valid", 32'(instr_valid), 32'd0);
        // 6: reset mid-stream with a pending load
        load("t6_ld", 6'd9, 32'h1234_5678);
        fetch("t6_f", 9'h024);
        step("t6_rst", 1'b1, 1'b1, 6'd9, 32'hffff_ffff, 1'b1, 9'h024, 1'b0);
        chk("t6_busy", 32'(busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) idle("t6_clr");
        fetch("t6_refetch", 9'h024);
        chk("t6_zero", instr, 32'h0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [8:0] a;
            a = $urandom_range(0, 3) == 0 ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 63) * 4);
            step("rnd", $urandom_range(0, 149) == 0, 1'($urandom), 6'($urandom), $urandom,
                 1'($urandom), a, $urandom_range(0, 3) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
